// File: rtl/weight_manager_pp.sv
// weight_manager_pp: ping-pong weight store. The CPU loads one buffer while the
// conv controller reads the other; a swap exchanges them at layer boundaries.
module weight_manager_pp #(
  parameter int NUM_BANKS  = 8,
  parameter int SLICES     = 8,
  parameter int WORD_W     = 72,
  parameter int DEPTH      = 4096,
  parameter int RD_LATENCY = 3,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [WORD_W-1:0]                      wr_data,
  input  logic                                   wr_last,
  input  logic                                   swap_req,
  output logic                                   swap_ack,
  input  logic                                   rd_en,
  input  logic [ADDR_WIDTH-1:0]                  rd_addr,
  output logic [NUM_BANKS-1:0][SLICES*WORD_W-1:0] rd_data,
  output logic                                   rd_valid,
  output logic                                   rd_buf,
  output logic                                   act_valid,
  output logic                                   wr_overflow,
  output logic                                   rd_err
);
  localparam int SL_W      = $clog2(SLICES);
  localparam int BK_W      = $clog2(NUM_BANKS);
  localparam int CNT_W     = SL_W + BK_W + ADDR_WIDTH;
  localparam int CAP       = NUM_BANKS * SLICES * DEPTH;
  localparam int ROW_W     = NUM_BANKS * SLICES * WORD_W;
  localparam int MEM_WORDS = 2 << ADDR_WIDTH;

  typedef enum logic [1:0] {EMPTY, LOADING, READY, ACTIVE} buf_state_t;

  buf_state_t             state_reg [2];
  buf_state_t             state_next [2];
  logic                   rd_buf_reg, rd_buf_next;
  logic                   act_valid_reg, act_valid_next;
  logic [CNT_W-1:0]       wr_cnt_reg, wr_cnt_next;
  logic                   swap_ack_reg;
  logic                   wr_overflow_reg, wr_overflow_next;
  logic                   rd_err_reg, rd_err_next;
  logic                   ready_en_reg;
  logic [RD_LATENCY-1:0]  vld_pipe_reg;

  logic wb, wr_accept, cnt_at_cap, wr_close, swap_fire, rd_issue;
  logic [ROW_W-1:0] ram_q, rd_row;

  assign wb         = ~rd_buf_reg;
  assign wr_ready   = ready_en_reg && (state_reg[wb] == EMPTY || state_reg[wb] == LOADING);
  assign wr_accept  = wr_valid && wr_ready;
  assign cnt_at_cap = (wr_cnt_reg == CNT_W'(CAP - 1));
  assign wr_close   = wr_accept && (wr_last || cnt_at_cap);
  // Swap only when no read is in flight, so every read returns its issue-time buffer.
  assign swap_fire  = swap_req && (state_reg[wb] == READY) && !(|vld_pipe_reg) && !rd_en;
  assign rd_issue   = rd_en && act_valid_reg;

  always_comb begin
    state_next       = state_reg;
    rd_buf_next      = rd_buf_reg;
    act_valid_next   = act_valid_reg;
    wr_cnt_next      = wr_cnt_reg;
    wr_overflow_next = wr_overflow_reg || (wr_accept && cnt_at_cap && !wr_last);
    rd_err_next      = rd_err_reg || (rd_en && !act_valid_reg);
    if (wr_accept) begin
      state_next[wb] = LOADING;
      wr_cnt_next    = wr_cnt_reg + CNT_W'(1);
      if (wr_close) begin
        state_next[wb] = READY;
        wr_cnt_next    = '0;
      end
    end
    if (swap_fire) begin
      state_next[wb]         = ACTIVE;
      state_next[rd_buf_reg] = EMPTY;
      rd_buf_next            = wb;
      act_valid_next         = 1'b1;
      wr_cnt_next            = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg[0]    <= EMPTY;
      state_reg[1]    <= EMPTY;
      rd_buf_reg      <= 1'b0;
      act_valid_reg   <= 1'b0;
      wr_cnt_reg      <= '0;
      swap_ack_reg    <= 1'b0;
      wr_overflow_reg <= 1'b0;
      rd_err_reg      <= 1'b0;
      ready_en_reg    <= 1'b0;
      vld_pipe_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      rd_buf_reg      <= rd_buf_next;
      act_valid_reg   <= act_valid_next;
      wr_cnt_reg      <= wr_cnt_next;
      swap_ack_reg    <= swap_fire;
      wr_overflow_reg <= wr_overflow_next;
      rd_err_reg      <= rd_err_next;
      ready_en_reg    <= 1'b1;
      vld_pipe_reg    <= RD_LATENCY'({vld_pipe_reg, rd_issue});
    end
  end

  logic [SL_W-1:0]       wr_slice;
  logic [BK_W-1:0]       wr_bank;
  logic [ADDR_WIDTH-1:0] wr_addr;
  assign wr_slice = wr_cnt_reg[SL_W-1:0];
  assign wr_bank  = wr_cnt_reg[SL_W +: BK_W];
  assign wr_addr  = wr_cnt_reg[SL_W+BK_W +: ADDR_WIDTH];

  // One RAM per (bank, slice); the buffer index is the top address bit.
  generate
    for (genvar gi = 0; gi < NUM_BANKS * SLICES; gi++) begin : g_ram
      logic [WORD_W-1:0] mem [MEM_WORDS];
      logic [WORD_W-1:0] q;
      always_ff @(posedge clk) begin
        if (wr_accept && ({wr_bank, wr_slice} == (BK_W+SL_W)'(gi)))
          mem[{wb, wr_addr}] <= wr_data;
        if (rd_issue)
          q <= mem[{rd_buf_reg, rd_addr}];
      end
      assign ram_q[gi*WORD_W +: WORD_W] = q;
    end

    if (RD_LATENCY == 1) begin : g_nodly
      assign rd_row = ram_q;
    end else begin : g_dly
      logic [ROW_W-1:0] pipe_reg [RD_LATENCY-1];
      always_ff @(posedge clk) begin
        pipe_reg[0] <= ram_q;
        for (int i = 1; i < RD_LATENCY - 1; i++)
          pipe_reg[i] <= pipe_reg[i-1];
      end
      assign rd_row = pipe_reg[RD_LATENCY-2];
    end
  endgenerate

  assign rd_valid    = vld_pipe_reg[RD_LATENCY-1];
  assign rd_data     = rd_valid ? rd_row : '0;
  assign rd_buf      = rd_buf_reg;
  assign act_valid   = act_valid_reg;
  assign swap_ack    = swap_ack_reg;
  assign wr_overflow = wr_overflow_reg;
  assign rd_err      = rd_err_reg;
endmodule
